// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10
  } sw_state_t;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX_DEF = 99;

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV enabled cycles.
module stopwatch_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en & (cnt_q == LAST);

endmodule

// File: rtl/stopwatch_mmss.sv
// Minutes:seconds stopwatch with start/stop/reset pulse controls.
module stopwatch_mmss
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter int MIN_MAX  = MIN_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       reset,
  output logic [7:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] status
);

  sw_state_t  state_q;
  sw_state_t  state_d;
  logic [7:0] min_q;
  logic [5:0] sec_q;
  logic       tick;
  logic       cnt_en;
  logic       cnt_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // reset beats stop beats start
  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start && !stop) state_d = RUNNING;
        RUNNING: if (stop) state_d = PAUSED;
        PAUSED:  if (start && !stop) state_d = RUNNING;
        default: state_d = IDLE;
      endcase
    end
  end

  // no tick on the edge that pauses or clears
  assign cnt_en  = (state_q == RUNNING) & ~stop & ~reset;
  assign cnt_clr = reset | (state_q == IDLE);

  stopwatch_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .clr (cnt_clr),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '0;
      sec_q <= '0;
    end else if (reset) begin
      min_q <= '0;
      sec_q <= '0;
    end else if (tick) begin
      if (sec_q == 6'(SEC_MAX)) begin
        sec_q <= '0;
        min_q <= (min_q == 8'(MIN_MAX)) ? '0 : min_q + 8'd1;
      end else begin
        sec_q <= sec_q + 6'd1;
      end
    end
  end

  assign minutes = min_q;
  assign seconds = sec_q;
  assign status  = state_q;

endmodule

// File: tb/tb_stopwatch_mmss.sv
// Scoreboard bench: two stopwatches (divide 1 and 4) against an elapsed-time model.
module tb_stopwatch_mmss;

  localparam int DIV_B = 4;
  localparam int MMAX  = 99;

  typedef struct {
    int min_a;
    int sec_a;
    int min_b;
    int sec_b;
    int st;
  } exp_t;

  logic       clk = 0;
  logic       rst = 1;
  logic       start = 0;
  logic       stop = 0;
  logic       reset = 0;
  logic [7:0] min_a, min_b;
  logic [5:0] sec_a, sec_b;
  logic [1:0] st_a, st_b;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  // model: state 0 idle, 1 running, 2 paused; run = counted running cycles
  int m_state = 0;
  int m_run = 0;

  always #5 clk = ~clk;

  stopwatch_mmss #(.TICK_DIV(1), .MIN_MAX(MMAX)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .reset(reset),
    .minutes(min_a), .seconds(sec_a), .status(st_a)
  );

  stopwatch_mmss #(.TICK_DIV(DIV_B), .MIN_MAX(MMAX)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .reset(reset),
    .minutes(min_b), .seconds(sec_b), .status(st_b)
  );

  function automatic exp_t predict();
    exp_t e;
    int ta, tb;
    ta = m_run % (60 * (MMAX + 1));
    tb = (m_run / DIV_B) % (60 * (MMAX + 1));
    e.min_a = ta / 60;
    e.sec_a = ta % 60;
    e.min_b = tb / 60;
    e.sec_b = tb % 60;
    e.st = m_state;
    return e;
  endfunction

  task automatic model_edge(input logic st, input logic sp, input logic rs,
                            input logic r);
    if (r || rs) begin
      m_state = 0;
      m_run = 0;
    end else if (m_state == 1) begin
      if (sp) m_state = 2;
      else m_run++;
    end else if (st && !sp) begin
      m_state = 1;
    end
  endtask

  task automatic step(input logic st, input logic sp, input logic rs,
                      input logic r = 0);
    @(negedge clk);
    #1;
    start = st;
    stop = sp;
    reset = rs;
    rst = r;
    model_edge(st, sp, rs, r);
    sb.push_back(predict());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (min_a != e.min_a || sec_a != e.sec_a || st_a != e.st ||
          min_b != e.min_b || sec_b != e.sec_b || st_b != e.st) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t got a=%0d:%0d/%0d b=%0d:%0d/%0d exp a=%0d:%0d b=%0d:%0d st=%0d",
                 $time, min_a, sec_a, st_a, min_b, sec_b, st_b,
                 e.min_a, e.sec_a, e.min_b, e.sec_b, e.st);
      end
    end
  end

  task automatic async_reset_check();
    @(negedge clk);
    #3;
    start = 0;
    stop = 0;
    reset = 0;
    rst = 1;
    model_edge(0, 0, 0, 1);
    #1;
    vectors++;
    if (min_a != 0 || sec_a != 0 || st_a != 0 ||
        min_b != 0 || sec_b != 0 || st_b != 0) begin
      miscompares++;
      $display("FAIL async_rst got a=%0d:%0d/%0d b=%0d:%0d/%0d exp all 0",
               min_a, sec_a, st_a, min_b, sec_b, st_b);
    end
  endtask

  initial begin
    int p;
    repeat (2) @(posedge clk);
    step(0, 0, 0, 0);
    idle(5);
    // start and run 30 seconds
    step(1, 0, 0);
    idle(30);
    // pause, hold, resume
    step(0, 1, 0);
    idle(10);
    step(1, 0, 0);
    idle(10);
    // minute carry
    step(0, 0, 1);
    step(1, 0, 0);
    idle(60);
    // full wrap at MIN_MAX:59
    step(0, 0, 1);
    step(1, 0, 0);
    idle(6000);
    // sync reset while running at 00:25
    step(0, 0, 1);
    step(1, 0, 0);
    idle(25);
    step(0, 0, 1);
    idle(3);
    // start+stop while running, start while running
    step(1, 0, 0);
    idle(7);
    step(1, 0, 0);
    idle(2);
    step(1, 1, 0);
    idle(3);
    step(1, 1, 0);
    idle(2);
    step(1, 0, 0);
    idle(9);
    // async reset mid-run
    async_reset_check();
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, 0, 0);
    idle(13);
    // random control pulses
    for (int i = 0; i < 2500; i++) begin
      p = $urandom_range(0, 99);
      step(p < 6, (p >= 6 && p < 10) || p == 99, p >= 97);
    end
    idle(2);
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain left=%0d exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
